// File: rtl/defines_package.sv
// Shared geometry/raster types: points, triangles, colours, fragments, edge function.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package defines_package;

    typedef logic [23:0] Color;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
    } Point2D;

    // p occupies the most significant 32 bits of the 96-bit bus.
    typedef struct packed {
        Point2D p;
        Point2D q;
        Point2D r;
    } Triangle2D;

    typedef struct packed {
        Point2D pos;
        Color   c;
    } Fragment;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } rast_state_t;

    // E(a,b,c) = (c.x-a.x)(b.y-a.y) - (c.y-a.y)(b.x-a.x).
    // 17-bit differences and 34-bit products are wide enough for every
    // 16-bit input, so the 35-bit result is exact.
    function automatic logic signed [34:0] edge_fn(input Point2D a, input Point2D b, input Point2D c);
        logic signed [16:0] dxc, dyb, dyc, dxb;
        logic signed [33:0] m0, m1;
        dxc = {c.x[15], c.x} - {a.x[15], a.x};
        dyb = {b.y[15], b.y} - {a.y[15], a.y};
        dyc = {c.y[15], c.y} - {a.y[15], a.y};
        dxb = {b.x[15], b.x} - {a.x[15], a.x};
        m0  = 34'(dxc) * 34'(dyb);
        m1  = 34'(dyc) * 34'(dxb);
        return 35'(m0) - 35'(m1);
    endfunction

    function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/tri_rasterizer_edge_eval.sv
// Combinational edge function E(a,b,c) over three packed Point2D inputs.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: a, b, c (32-bit Point2D each) in; e (35-bit signed) out.
module edge_eval
    import defines_package::*;
(
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    input  logic [31:0]        c,
    output logic signed [34:0] e
);

    assign e = edge_fn(Point2D'(a), Point2D'(b), Point2D'(c));

endmodule

// File: rtl/tri_rasterizer.sv
// Bounding-box scan rasterizer: one triangle in, one covered-pixel fragment per cycle out.
// Latency: accept at T, SETUP at T+1, first candidate at T+2; tri_done after the last candidate.
// Backpressure: a covered pixel holds frag_x/frag_y/frag_color until frag_ready; tri_ready only in IDLE.
// Ports: clk, rst_n (sync, active-low); tri_valid/tri_ready/tri_in/tri_color (triangle input);
//        frag_valid/frag_ready/frag_x/frag_y/frag_color (fragment stream); tri_done (1-cycle pulse).
// Config: define RAST_CLIP_EN to clamp the bounding box to the SCREEN_W x SCREEN_H screen.
module tri_rasterizer
    import defines_package::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [95:0]        tri_in,
    input  logic [23:0]        tri_color,
    output logic               frag_valid,
    input  logic               frag_ready,
    output logic signed [15:0] frag_x,
    output logic signed [15:0] frag_y,
    output logic [23:0]        frag_color,
    output logic               tri_done
);

    rast_state_t state, nstate;

    Triangle2D          tri_r;
    Color               color_r;
    logic               a_neg;
    logic signed [15:0] xmin_r, xmax_r, ymax_r;
    logic signed [15:0] cur_x, cur_y;

    logic signed [15:0] bx0, bx1, by0, by1;
    logic               bbox_empty;

    logic [31:0]        e0_a, e0_b, e0_c;
    logic signed [34:0] w0, w1, w2;
    logic               all_ge, all_le, covered, advance, last_pix;
    Point2D             cur_pt;
    Fragment            frag;

    // Bounding box of the latched triangle, optionally clamped to the screen.
    always_comb begin
        bx0 = min3(tri_r.p.x, tri_r.q.x, tri_r.r.x);
        bx1 = max3(tri_r.p.x, tri_r.q.x, tri_r.r.x);
        by0 = min3(tri_r.p.y, tri_r.q.y, tri_r.r.y);
        by1 = max3(tri_r.p.y, tri_r.q.y, tri_r.r.y);
`ifdef RAST_CLIP_EN
        if (bx0 < 16'sd0)                bx0 = 16'sd0;
        if (by0 < 16'sd0)                by0 = 16'sd0;
        if (bx1 > 16'(SCREEN_W - 1))     bx1 = 16'(SCREEN_W - 1);
        if (by1 > 16'(SCREEN_H - 1))     by1 = 16'(SCREEN_H - 1);
`endif
        bbox_empty = (bx0 > bx1) || (by0 > by1);
    end

    assign cur_pt = '{x: cur_x, y: cur_y};

    // Instance 0 computes the area term A = E(p,q,r) during SETUP, w0 otherwise.
    assign e0_a = (state == SETUP) ? tri_r.p : tri_r.q;
    assign e0_b = (state == SETUP) ? tri_r.q : tri_r.r;
    assign e0_c = (state == SETUP) ? tri_r.r : cur_pt;

    edge_eval u_e0 (.a(e0_a),    .b(e0_b),    .c(e0_c),   .e(w0));
    edge_eval u_e1 (.a(tri_r.r), .b(tri_r.p), .c(cur_pt), .e(w1));
    edge_eval u_e2 (.a(tri_r.p), .b(tri_r.q), .c(cur_pt), .e(w2));

    // Inclusive boundaries; the sign of A selects which half-plane counts as inside.
    assign all_ge   = !w0[34] && !w1[34] && !w2[34];
    assign all_le   = (w0[34] || (w0 == '0)) && (w1[34] || (w1 == '0)) && (w2[34] || (w2 == '0));
    assign covered  = a_neg ? all_le : all_ge;
    assign advance  = (state == SCAN) && (!covered || frag_ready);
    assign last_pix = (cur_x == xmax_r) && (cur_y == ymax_r);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    // Next-state logic
    always_comb begin
        nstate = state;
        case (state)
            IDLE:  if (tri_valid) nstate = SETUP;
            SETUP: nstate = ((w0 == '0) || bbox_empty) ? DONE : SCAN;
            SCAN:  if (advance && last_pix) nstate = DONE;
            DONE:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Outputs: the fragment is the current cursor, so it stays put while stalled.
    always_comb begin
        tri_ready  = (state == IDLE);
        tri_done   = (state == DONE);
        frag_valid = (state == SCAN) && covered;
        frag       = '{pos: cur_pt, c: color_r};
        frag_x     = frag.pos.x;
        frag_y     = frag.pos.y;
        frag_color = frag.c;
    end

    // Triangle latch, setup results and scan cursor.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tri_r   <= '0;
            color_r <= '0;
            a_neg   <= 1'b0;
            xmin_r  <= '0;
            xmax_r  <= '0;
            ymax_r  <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
        end else begin
            case (state)
                IDLE: if (tri_valid) begin
                    tri_r   <= Triangle2D'(tri_in);
                    color_r <= tri_color;
                end
                SETUP: begin
                    a_neg  <= w0[34];
                    xmin_r <= bx0;
                    xmax_r <= bx1;
                    ymax_r <= by1;
                    cur_x  <= bx0;
                    cur_y  <= by0;
                end
                SCAN: if (advance) begin
                    if (cur_x == xmax_r) begin
                        cur_x <= xmin_r;
                        cur_y <= cur_y + 16'sd1;
                    end else begin
                        cur_x <= cur_x + 16'sd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_rasterizer.sv
// Self-checking bench for tri_rasterizer: directed table, random triangles vs. a reference model, reset corners.
// Latency: n/a.
// Backpressure: frag_ready driven always-high or randomly per run.
module tb_tri_rasterizer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               tri_valid;
    logic               tri_ready;
    logic [95:0]        tri_in;
    logic [23:0]        tri_color;
    logic               frag_valid;
    logic               frag_ready;
    logic signed [15:0] frag_x, frag_y;
    logic [23:0]        frag_color;
    logic               tri_done;

    always #5 clk = ~clk;

    tri_rasterizer dut (
        .clk(clk), .rst_n(rst_n),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_in(tri_in), .tri_color(tri_color),
        .frag_valid(frag_valid), .frag_ready(frag_ready),
        .frag_x(frag_x), .frag_y(frag_y), .frag_color(frag_color),
        .tri_done(tri_done)
    );

    typedef struct {
        int x;
        int y;
        logic [23:0] c;
    } frag_t;

    typedef struct {
        int px, py, qx, qy, rx, ry;
        int rmode;      // 0: frag_ready always 1, 1: random
        int exp_n;
        int fx, fy, lx, ly;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    frag_t got_q[$];
    frag_t exp_q[$];
    int    exp_cand;
    int    r_done_cyc, r_first_cyc, r_ndone;

    function automatic void chk(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endfunction

    function automatic longint efn(input longint ax, ay, bx, by, cx, cy);
        return (cx - ax) * (by - ay) - (cy - ay) * (bx - ax);
    endfunction

    // Reference: walk the bounding box row-major and keep every pixel whose three
    // edge values all agree in sign with the triangle's area term.
    task automatic model(input vec_t v, input logic [23:0] col);
        longint a, w0, w1, w2;
        int xmin, xmax, ymin, ymax;
        exp_q.delete();
        exp_cand = 0;
        a    = efn(v.px, v.py, v.qx, v.qy, v.rx, v.ry);
        xmin = (v.px < v.qx) ? v.px : v.qx;  xmin = (v.rx < xmin) ? v.rx : xmin;
        xmax = (v.px > v.qx) ? v.px : v.qx;  xmax = (v.rx > xmax) ? v.rx : xmax;
        ymin = (v.py < v.qy) ? v.py : v.qy;  ymin = (v.ry < ymin) ? v.ry : ymin;
        ymax = (v.py > v.qy) ? v.py : v.qy;  ymax = (v.ry > ymax) ? v.ry : ymax;
`ifdef RAST_CLIP_EN
        if (xmin < 0) xmin = 0;
        if (ymin < 0) ymin = 0;
        if (xmax > 639) xmax = 639;
        if (ymax > 479) ymax = 479;
`endif
        if (a == 0 || xmin > xmax || ymin > ymax) return;
        exp_cand = (xmax - xmin + 1) * (ymax - ymin + 1);
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                w0 = efn(v.qx, v.qy, v.rx, v.ry, x, y);
                w1 = efn(v.rx, v.ry, v.px, v.py, x, y);
                w2 = efn(v.px, v.py, v.qx, v.qy, x, y);
                if ((a > 0 && w0 >= 0 && w1 >= 0 && w2 >= 0) ||
                    (a < 0 && w0 <= 0 && w1 <= 0 && w2 <= 0))
                    exp_q.push_back('{x: x, y: y, c: col});
            end
        end
    endtask

    function automatic logic [95:0] pack_tri(input vec_t v);
        return {16'(v.px), 16'(v.py), 16'(v.qx), 16'(v.qy), 16'(v.rx), 16'(v.ry)};
    endfunction

    // Offer one triangle and collect its fragment stream; k counts cycles after the accept edge.
    task automatic run_tri(input vec_t v, input logic [23:0] col);
        int  k;
        logic stalled;
        int  sx, sy;
        got_q.delete();
        r_done_cyc = -1; r_first_cyc = -1; r_ndone = 0;
        stalled = 1'b0; sx = 0; sy = 0;
        @(negedge clk);
        chk("ready_before_accept", tri_ready, 1);
        tri_valid = 1'b1; tri_in = pack_tri(v); tri_color = col;
        @(negedge clk);
        tri_valid = 1'b0;
        k = 1;
        chk("ready_low_in_setup", tri_ready, 0);
        while (r_done_cyc < 0) begin
            if (k > 3000) begin
                chk("timeout_waiting_done", 1, 0);
                return;
            end
            frag_ready = (v.rmode == 0) ? 1'b1 : 1'($urandom_range(1));
            if (stalled) begin
                chk("stall_valid_held", frag_valid, 1);
                chk("stall_x_held", frag_x, sx);
                chk("stall_y_held", frag_y, sy);
            end
            if (tri_done) begin
                r_ndone++;
                r_done_cyc = k;
                chk("ready_low_at_done", tri_ready, 0);
            end
            if (frag_valid && r_first_cyc < 0) r_first_cyc = k;
            if (frag_valid && frag_ready)
                got_q.push_back('{x: int'(frag_x), y: int'(frag_y), c: frag_color});
            stalled = frag_valid && !frag_ready;
            sx = int'(frag_x); sy = int'(frag_y);
            @(negedge clk);
            k++;
        end
        chk("done_single_pulse", tri_done, 0);
        chk("ready_after_done", tri_ready, 1);
        frag_ready = 1'b1;
    endtask

    task automatic compare_stream(input string tag);
        int mism;
        mism = 0;
        chk({tag, "_frag_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y || got_q[i].c !== exp_q[i].c)
                mism++;
        chk({tag, "_frag_contents_mismatches"}, mism, 0);
    endtask

    vec_t  tbl[5];
    vec_t  rv;
    logic [23:0] col;

    initial begin
        tbl[0] = '{0, 0, 4, 0, 0, 4,  0, 15, 0, 0, 0, 4};
        tbl[1] = '{0, 0, 0, 4, 4, 0,  0, 15, 0, 0, 0, 4};
        tbl[2] = '{0, 0, 2, 2, 4, 4,  0, 0, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 4, 0, 0, 4,  1, 15, 0, 0, 0, 4};
`ifdef RAST_CLIP_EN
        tbl[4] = '{-10, -10, 10, -10, -10, 10,  0, 1, 0, 0, 0, 0};
`else
        tbl[4] = '{-10, -10, 10, -10, -10, 10,  0, 231, -10, -10, -10, 10};
`endif

        rst_n = 1'b0; tri_valid = 1'b1; tri_in = pack_tri(tbl[0]);
        tri_color = 24'hABCDEF; frag_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_frag_valid", frag_valid, 0);
        chk("rst_tri_done", tri_done, 0);
        chk("rst_tri_ready", tri_ready, 1);
        chk("rst_frag_x", frag_x, 0);
        chk("rst_frag_y", frag_y, 0);
        chk("rst_frag_color", frag_color, 0);
        rst_n = 1'b1; tri_valid = 1'b0;
        @(negedge clk);
        chk("idle_after_reset_ready", tri_ready, 1);
        chk("idle_after_reset_valid", frag_valid, 0);

        for (int i = 0; i < 5; i++) begin
            col = 24'h100000 + 24'(i);
            run_tri(tbl[i], col);
            model(tbl[i], col);
            chk($sformatf("vec%0d_count", i), got_q.size(), tbl[i].exp_n);
            chk($sformatf("vec%0d_done_count", i), r_ndone, 1);
            if (tbl[i].exp_n > 0 && got_q.size() > 0) begin
                chk($sformatf("vec%0d_first_x", i), got_q[0].x, tbl[i].fx);
                chk($sformatf("vec%0d_first_y", i), got_q[0].y, tbl[i].fy);
                chk($sformatf("vec%0d_last_x", i), got_q[got_q.size()-1].x, tbl[i].lx);
                chk($sformatf("vec%0d_last_y", i), got_q[got_q.size()-1].y, tbl[i].ly);
            end
            if (tbl[i].exp_n == 0)
                chk($sformatf("vec%0d_degenerate_done_cycle", i), r_done_cyc, 2);
            if (i == 0)
                chk("vec0_first_frag_cycle", r_first_cyc, 2);
            if (tbl[i].rmode == 0)
                chk($sformatf("vec%0d_done_cycle", i), r_done_cyc, 2 + exp_cand);
            compare_stream($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 25; i++) begin
            rv.px = $urandom_range(16) - 8;  rv.py = $urandom_range(16) - 8;
            rv.qx = $urandom_range(16) - 8;  rv.qy = $urandom_range(16) - 8;
            rv.rx = $urandom_range(16) - 8;  rv.ry = $urandom_range(16) - 8;
            rv.rmode = $urandom_range(1);
            rv.exp_n = 0; rv.fx = 0; rv.fy = 0; rv.lx = 0; rv.ly = 0;
            col = 24'($urandom);
            run_tri(rv, col);
            model(rv, col);
            compare_stream($sformatf("rand%0d", i));
            chk($sformatf("rand%0d_done_count", i), r_ndone, 1);
            if (rv.rmode == 0)
                chk($sformatf("rand%0d_done_cycle", i), r_done_cyc, 2 + exp_cand);
        end

        // Reset pulse in the middle of a scan.
        @(negedge clk);
        tri_valid = 1'b1; tri_in = pack_tri(tbl[0]); tri_color = 24'h0F0F0F; frag_ready = 1'b1;
        @(negedge clk);
        tri_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midscan_in_progress", tri_ready, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midscan_rst_frag_valid", frag_valid, 0);
        chk("midscan_rst_tri_ready", tri_ready, 1);
        chk("midscan_rst_tri_done", tri_done, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midscan_no_done", tri_done, 0);
        end
        run_tri(tbl[0], 24'h00FF00);
        model(tbl[0], 24'h00FF00);
        compare_stream("after_reset");
        chk("after_reset_done_count", r_ndone, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
